// File: rtl/hdmi_pll_rstseq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdmi_pll_rstseq: PLL reset pulse generator and lock qualifier that       |
// | releases the video-domain reset only after a stable PLL lock.            |
// | Optional macro: HDMI_PLL_RSTSEQ_GLITCH_FILTER_EN (4-cycle lock-loss      |
// | filter while in RUN).                                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hdmi_pll_rstseq #(
  parameter int unsigned RESET_PULSE_CYCLES  = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       video_reset,
  output logic       locked,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  localparam int unsigned CNT_MAX_AB = (RESET_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                       RESET_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_MAX    = (CNT_MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                       CNT_MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CW         = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] c_one      = CW'(1);
  localparam logic [CW-1:0] c_rst_last = CW'(RESET_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] c_stb_last = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] c_tmo_last = CW'(LOCK_TIMEOUT_CYCLES - 1);
`ifdef HDMI_PLL_RSTSEQ_GLITCH_FILTER_EN
  localparam logic [CW-1:0] c_glitch_last = CW'(3);
`endif

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync2_q;
  logic          pll_reset_q;
  logic          video_reset_q;
  logic          locked_q;
  logic [7:0]    relock_q, relock_d;
  logic          timeout_q, timeout_d;
  logic          lock_s;
  logic          lock_loss;

  assign lock_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    relock_d  = relock_q;
    timeout_d = timeout_q;
    lock_loss = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == c_rst_last) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a timeout landing on the same cycle.
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == c_tmo_last) begin
          state_d   = ST_PLL_RST;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == c_stb_last) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      ST_RUN: begin
`ifdef HDMI_PLL_RSTSEQ_GLITCH_FILTER_EN
        // The shared counter tracks consecutive low lock samples here.
        if (lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == c_glitch_last) begin
          lock_loss = 1'b1;
        end else begin
          cnt_d = cnt_q + c_one;
        end
`else
        lock_loss = !lock_s;
`endif
        if (lock_loss) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          if (relock_q != 8'hFF) begin
            relock_d = relock_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      state_q       <= ST_PLL_RST;
      cnt_q         <= '0;
      pll_reset_q   <= 1'b1;
      video_reset_q <= 1'b1;
      locked_q      <= 1'b0;
      relock_q      <= 8'd0;
      timeout_q     <= 1'b0;
    end else begin
      sync1_q       <= pll_lock;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      // pll_reset tracks the state exactly; video outputs lag it by one cycle.
      pll_reset_q   <= (state_d == ST_PLL_RST);
      video_reset_q <= (state_q != ST_RUN);
      locked_q      <= (state_q == ST_RUN);
      relock_q      <= relock_d;
      timeout_q     <= timeout_d;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign video_reset  = video_reset_q;
  assign locked       = locked_q;
  assign relock_count = relock_q;
  assign timeout_err  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pll_rstseq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hdmi_pll_rstseq: directed-vector bench for hdmi_pll_rstseq with       |
// | RESET_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hdmi_pll_rstseq;

`ifdef HDMI_PLL_RSTSEQ_GLITCH_FILTER_EN
  localparam int DROP = 4;
`else
  localparam int DROP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic       video_reset;
  logic       locked;
  logic [7:0] relock_count;
  logic       timeout_err;
  logic [11:0] act;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       pr;
    logic       vr;
    logic       lk;
    logic [7:0] rc;
    logic       te;
  } vec_t;

  vec_t vecs[25];

  always #5 clk = ~clk;

  hdmi_pll_rstseq #(
    .RESET_PULSE_CYCLES (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .video_reset (video_reset),
    .locked      (locked),
    .relock_count(relock_count),
    .timeout_err (timeout_err)
  );

  assign act = {pll_reset, video_reset, locked, relock_count, timeout_err};

  function automatic logic [11:0] pk(input logic pr, input logic vr, input logic lk,
                                     input logic [7:0] rc, input logic te);
    return {pr, vr, lk, rc, te};
  endfunction

  task automatic step(input logic r, input logic l);
    reset    = r;
    pll_lock = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic relock(output int pr_len, output logic ok);
    logic seen_drop;
    seen_drop = 1'b0;
    pr_len    = 0;
    ok        = 1'b0;
    for (int i = 0; i < DROP; i++) begin
      step(1'b0, 1'b0);
      if (pll_reset) pr_len++;
    end
    for (int n = 0; n < 80 && !ok; n++) begin
      step(1'b0, 1'b1);
      if (pll_reset) pr_len++;
      if (!locked) seen_drop = 1'b1;
      if (seen_drop && locked) ok = 1'b1;
    end
  endtask

  initial begin
    int   exp_rc;
    int   pr_len;
    logic ok;

    // Power-up lock: reset released at row 1, pll_lock rises at row 11.
    for (int k = 0; k < 25; k++) begin
      vecs[k].rst  = (k == 0);
      vecs[k].lock = (k >= 11);
      vecs[k].pr   = (k <= 3);
      vecs[k].vr   = (k <= 21);
      vecs[k].lk   = (k >= 22);
      vecs[k].rc   = 8'd0;
      vecs[k].te   = 1'b0;
    end

    for (int k = 0; k < 25; k++) begin
      step(vecs[k].rst, vecs[k].lock);
      chk($sformatf("vec%0d", k), 32'(act),
          32'(pk(vecs[k].pr, vecs[k].vr, vecs[k].lk, vecs[k].rc, vecs[k].te)));
    end

    // Two-cycle lock drop in RUN (rows 25,26).
    for (int k = 25; k <= 41; k++) begin
      step(1'b0, (k >= 27));
`ifdef HDMI_PLL_RSTSEQ_GLITCH_FILTER_EN
      chk($sformatf("drop2_k%0d", k), 32'(act), 32'(pk(1'b0, 1'b0, 1'b1, 8'd0, 1'b0)));
`else
      chk($sformatf("drop2_k%0d", k), 32'(act),
          32'(pk((k >= 27 && k <= 30), (k >= 28 && k <= 40), !(k >= 28 && k <= 40),
                 (k >= 27) ? 8'd1 : 8'd0, 1'b0)));
`endif
    end
`ifdef HDMI_PLL_RSTSEQ_GLITCH_FILTER_EN
    exp_rc = 0;
`else
    exp_rc = 1;
`endif

    // Repeated lock losses until relock_count saturates.
    for (int i = 0; i < 260; i++) begin
      relock(pr_len, ok);
      exp_rc = (exp_rc >= 255) ? 255 : exp_rc + 1;
      chk($sformatf("relock_ok_%0d", i), 32'(ok), 32'd1);
      chk($sformatf("pll_reset_len_%0d", i), 32'(pr_len), 32'd4);
      chk($sformatf("relock_count_%0d", i), 32'(relock_count), 32'(exp_rc));
    end

    // Reset mid-RUN.
    step(1'b1, 1'b1);
    chk("reset_mid_run", 32'(act), 32'(pk(1'b1, 1'b1, 1'b0, 8'd0, 1'b0)));

    // Lock held low: re-pulse every 36 cycles, then lock arrives at j=81.
    for (int j = 1; j <= 92; j++) begin
      step(1'b0, (j >= 81));
      chk($sformatf("timeout_j%0d", j), 32'(act),
          32'(pk((j <= 80) ? ((j % 36) < 4) : 1'b0, (j <= 91), (j >= 92), 8'd0, (j >= 36))));
    end

    // Lock and timeout on the same cycle: lock wins, no timeout flag.
    step(1'b1, 1'b0);
    chk("reset_after_timeout", 32'(act), 32'(pk(1'b1, 1'b1, 1'b0, 8'd0, 1'b0)));
    for (int j = 1; j <= 45; j++) begin
      step(1'b0, (j >= 34));
      chk($sformatf("tie_j%0d", j), 32'(act),
          32'(pk((j <= 3), (j <= 44), (j >= 45), 8'd0, 1'b0)));
    end

    // Lock one cycle too late: timeout fires.
    step(1'b1, 1'b0);
    for (int j = 1; j <= 37; j++) begin
      step(1'b0, (j >= 35));
      chk($sformatf("late_j%0d", j), 32'(act),
          32'(pk((j <= 3) || (j >= 36), 1'b1, 1'b0, 8'd0, (j >= 36))));
    end

    // One-cycle drop during STABLE: back to WAIT_LOCK, RUN 8 cycles after recovery.
    step(1'b1, 1'b1);
    for (int j = 1; j <= 21; j++) begin
      step(1'b0, (j != 9));
      chk($sformatf("stable_drop_j%0d", j), 32'(act),
          32'(pk((j <= 3), (j <= 20), (j >= 21), 8'd0, 1'b0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdmi_pll_rstseq.md
HDMI_PLL_RSTSEQ -- requirements
Module: hdmi_pll_rstseq

Interface
REQ-001 SHALL have parameter RESET_PULSE_CYCLES, default 16: cycles pll_reset is held high per reset attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: continuous synchronized-lock cycles required before releasing video reset.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum cycles waiting for lock before retrying.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; free-running board clock, not a PLL output.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pll_lock, input, 1 bit: PLL LOCK output; asynchronous to clk.
REQ-007 SHALL have port pll_reset, output, 1 bit: drives the PLL RESET input; active-high.
REQ-008 SHALL have port video_reset, output, 1 bit: active-high reset for logic clocked by the PLL outputs.
REQ-009 SHALL have port locked, output, 1 bit: high only in state RUN.
REQ-010 SHALL have port relock_count, output, 8 bits: count of lock losses detected in RUN; saturates at 255.
REQ-011 SHALL have port timeout_err, output, 1 bit: sticky flag set on any lock timeout.

Function
REQ-012 SHALL pass pll_lock through a 2-flop synchronizer; all internal decisions use the synchronized value (lock_s), 2-cycle latency.
REQ-013 SHALL implement the states PLL_RST, WAIT_LOCK, STABLE and RUN, with one shared counter sized for the largest parameter.
REQ-014 In PLL_RST: pll_reset=1, video_reset=1; after exactly RESET_PULSE_CYCLES cycles in the state -> WAIT_LOCK with counter cleared.
REQ-015 In WAIT_LOCK: pll_reset=0, video_reset=1; lock_s=1 -> STABLE with counter cleared.
REQ-016 In WAIT_LOCK: counter reaching LOCK_TIMEOUT_CYCLES-1 with lock_s=0 -> PLL_RST, and set timeout_err.
REQ-017 If lock_s=1 and timeout occur in the same cycle in WAIT_LOCK, SHALL take lock (-> STABLE) and SHALL NOT set timeout_err.
REQ-018 In STABLE: video_reset=1; lock_s=0 -> WAIT_LOCK with counter cleared and no relock_count increment; LOCK_STABLE_CYCLES consecutive lock_s=1 cycles -> RUN.
REQ-019 In RUN: video_reset=0, locked=1; a detected lock loss -> PLL_RST, and relock_count increments (saturating).
REQ-020 video_reset and locked SHALL be registered outputs that change the cycle after the state transition; they SHALL never glitch.
REQ-021 pll_lock toggling while in PLL_RST SHALL be ignored.

Reset
REQ-022 While reset=1: state=PLL_RST, counter=0, synchronizer flops=0, pll_reset=1, video_reset=1, locked=0, relock_count=0, timeout_err=0.
REQ-023 reset asserted in any state, including mid-RUN, SHALL take effect on the next clk edge; relock_count SHALL NOT increment for that exit.
REQ-024 After reset deasserts, the first PLL_RST pulse SHALL last the full RESET_PULSE_CYCLES.

Configuration
REQ-025 Macro HDMI_PLL_RSTSEQ_GLITCH_FILTER_EN defined: lock loss in RUN SHALL be detected only after lock_s is low for 4 consecutive cycles; shorter low pulses SHALL be ignored with no state change.
REQ-026 Macro HDMI_PLL_RSTSEQ_GLITCH_FILTER_EN undefined: a single lock_s=0 sample in RUN SHALL count as lock loss.

Verification (RESET_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32)
REQ-027 Reset released, pll_lock rises 10 cycles later and stays high -> pll_reset high for exactly 4 cycles; locked=1 and video_reset=0 at a deterministic cycle count (synchronizer + 8 stable cycles + 1 register stage).
REQ-028 pll_lock held low -> pll_reset re-pulses every 36 cycles (4 pulse + 32 wait); timeout_err=1 after the first timeout and stays high after lock arrives.
REQ-029 pll_lock drops for 1 cycle during STABLE at cycle 5 -> state returns to WAIT_LOCK, then reaches RUN 8 stable cycles after recovery; relock_count=0.
REQ-030 In RUN, pll_lock low for 2 cycles -> with the macro defined, no change; without it, video_reset=1, new 4-cycle pll_reset pulse, relock_count=1.
REQ-031 260 lock-loss/relock cycles in RUN -> relock_count saturates at 255; reset asserted mid-RUN -> all outputs return to reset values on the next edge and relock_count=0.
